fir3_stream_sequencer: RTL and testbench

Sequencer placed between a serial sample stream and the 3-parallel unfolded FIR_FILTER. It gathers serial input samples into triplets and issues each triplet to the filter as one DIN3k/DIN3k1/DIN3k2 transfer with a VIN strobe. It captures the filter's DOUT triplets on VOUT into a triplet FIFO and re-serializes them onto a ready/valid output. A credit counter limits issued-but-not-returned triplets so the FIFO can never overflow, which gives backpressure end-to-end.

---
 rtl/fir3_stream_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fir3_stream_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fir3_stream_sequencer.sv
// Gathers serial samples into triplets for a 3-parallel FIR, then captures result
// triplets in a credit-protected FIFO and re-serializes them onto a ready/valid output.
module fir3_stream_sequencer #(
  parameter int unsigned NBIT       = 9,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NBIT-1:0] IN_DATA,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic [NBIT-1:0] FIR_DIN3k,
  output logic [NBIT-1:0] FIR_DIN3k1,
  output logic [NBIT-1:0] FIR_DIN3k2,
  output logic            FIR_VIN,
  input  logic [NBIT-1:0] FIR_DOUT3k,
  input  logic [NBIT-1:0] FIR_DOUT3k1,
  input  logic [NBIT-1:0] FIR_DOUT3k2,
  input  logic            FIR_VOUT,
  output logic [NBIT-1:0] OUT_DATA,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic            ERR
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned UW = CW + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = 3 * NBIT;

  logic [1:0]      in_phase_q, in_phase_d;
  logic [NBIT-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [TW-1:0]   din_q, din_d;
  logic            vin_q, vin_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]      out_phase_q, out_phase_d;
  logic            err_q, err_d;
  logic [TW-1:0]   fifo_mem_q [FIFO_DEPTH];

  logic          accept_c, issue_c, push_c, pop_c, beat_c, credit_zero_c;
  logic [UW-1:0] used_c;
  logic [TW-1:0] head_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // No credit left when FIFO occupancy plus outstanding triplets fill the FIFO.
  assign used_c        = UW'(fifo_cnt_q) + UW'(inflight_q);
  assign credit_zero_c = (used_c == UW'(FIFO_DEPTH));

  assign IN_READY  = (in_phase_q != 2'd2) || !credit_zero_c;
  assign accept_c  = IN_VALID && IN_READY;
  assign issue_c   = accept_c && (in_phase_q == 2'd2);
  assign push_c    = FIR_VOUT && (inflight_q != '0);
  assign OUT_VALID = (fifo_cnt_q != '0);
  assign beat_c    = OUT_VALID && OUT_READY;
  assign pop_c     = beat_c && (out_phase_q == 2'd2);

  assign head_c = fifo_mem_q[rd_ptr_q];

  always_comb begin
    case (out_phase_q)
      2'd0:    OUT_DATA = head_c[TW-1 -: NBIT];
      2'd1:    OUT_DATA = head_c[2*NBIT-1 -: NBIT];
      default: OUT_DATA = head_c[NBIT-1:0];
    endcase
  end

  assign FIR_DIN3k  = din_q[TW-1 -: NBIT];
  assign FIR_DIN3k1 = din_q[2*NBIT-1 -: NBIT];
  assign FIR_DIN3k2 = din_q[NBIT-1:0];
  assign FIR_VIN    = vin_q;
  assign ERR        = err_q;

  always_comb begin
    in_phase_d  = in_phase_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    din_d       = din_q;
    vin_d       = 1'b0;
    inflight_d  = inflight_q;
    fifo_cnt_d  = fifo_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_phase_d = out_phase_q;
    err_d       = err_q;

    if (accept_c) begin
      case (in_phase_q)
        2'd0: begin
          s0_d       = IN_DATA;
          in_phase_d = 2'd1;
        end
        2'd1: begin
          s1_d       = IN_DATA;
          in_phase_d = 2'd2;
        end
        2'd2: begin
          din_d      = {s0_q, s1_q, IN_DATA};
          vin_d      = 1'b1;
          in_phase_d = 2'd0;
        end
        default: in_phase_d = 2'd0;
      endcase
    end

    // A return with nothing outstanding is dropped and flagged.
    if (FIR_VOUT && (inflight_q == '0)) err_d = 1'b1;
    if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);

    if (beat_c) begin
      if (out_phase_q == 2'd2) begin
        out_phase_d = 2'd0;
        rd_ptr_d    = ptr_inc(rd_ptr_q);
      end else begin
        out_phase_d = out_phase_q + 2'd1;
      end
    end

    case ({issue_c, push_c})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    case ({push_c, pop_c})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      in_phase_q  <= 2'd0;
      s0_q        <= '0;
      s1_q        <= '0;
      din_q       <= '0;
      vin_q       <= 1'b0;
      inflight_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_phase_q <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      in_phase_q  <= in_phase_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      din_q       <= din_d;
      vin_q       <= vin_d;
      inflight_q  <= inflight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_phase_q <= out_phase_d;
      err_q       <= err_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by fifo_cnt_q.
  always_ff @(posedge CLK) begin
    if (!RST && push_c) fifo_mem_q[wr_ptr_q] <= {FIR_DOUT3k, FIR_DOUT3k1, FIR_DOUT3k2};
  end

endmodule

// File: tb/tb_fir3_stream_sequencer.sv
// Randomized scoreboard bench for fir3_stream_sequencer with a behavioural
// filter stand-in (fixed bit transform, in-order, variable latency).
module tb_fir3_stream_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] din0, din1, din2;
  logic       vin;
  logic [8:0] dout0 = '0, dout1 = '0, dout2 = '0;
  logic       vout = 1'b0;
  logic [8:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       err;

  always #5 clk = ~clk;

  fir3_stream_sequencer #(.NBIT(9), .FIFO_DEPTH(4)) dut (
    .CLK(clk), .RST(rst),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .FIR_DIN3k(din0), .FIR_DIN3k1(din1), .FIR_DIN3k2(din2), .FIR_VIN(vin),
    .FIR_DOUT3k(dout0), .FIR_DOUT3k1(dout1), .FIR_DOUT3k2(dout2), .FIR_VOUT(vout),
    .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .ERR(err)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0, n_vin = 0, n_acc = 0;
  logic [26:0] exp_iss_q [$];
  logic [8:0]  exp_out_q [$];
  logic [8:0]  gath      [$];
  logic [26:0] flt_q     [$];
  int          flt_due   [$];
  int          last_due = 0;
  int          lat_lo = 1, lat_hi = 3;
  bit          force_vout = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic miss(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT produced data, want none queued (cycle %0d)", nm, cyc);
  endtask

  // Stand-in filter response: any fixed bit-exact map with distinct per-lane effect.
  function automatic logic [26:0] fx(input logic [26:0] t);
    return t ^ 27'h2A5C3B1;
  endfunction

  // Reference: every third accepted sample completes a triplet.
  task automatic model_accept(input logic [8:0] d);
    logic [26:0] t, r;
    n_acc++;
    gath.push_back(d);
    if (gath.size() == 3) begin
      t = {gath[0], gath[1], gath[2]};
      r = fx(t);
      exp_iss_q.push_back(t);
      exp_out_q.push_back(r[26:18]);
      exp_out_q.push_back(r[17:9]);
      exp_out_q.push_back(r[8:0]);
      gath.delete();
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [8:0] d, input bit ordy);
    int due;
    @(posedge clk);
    #1;
    cyc++;
    if (vin) n_vin++;
    rst = r;
    if (r) begin
      flt_q.delete(); flt_due.delete(); exp_iss_q.delete(); exp_out_q.delete(); gath.delete();
      last_due = 0;
    end else if (vin) begin
      flt_q.push_back(fx({din0, din1, din2}));
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      flt_due.push_back(due);
    end
    vout = 1'b0;
    if (force_vout) begin
      vout = 1'b1;
      {dout0, dout1, dout2} = 27'h7FFFFFF;
    end else if (!r && flt_due.size() != 0 && flt_due[0] <= cyc) begin
      {dout0, dout1, dout2} = flt_q.pop_front();
      void'(flt_due.pop_front());
      vout = 1'b1;
    end
    in_valid = v; in_data = d; out_ready = ordy;
    #1;
    if (!r && v && in_ready) model_accept(d);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_out_q.size() != 0 || flt_q.size() != 0 || exp_iss_q.size() != 0); i++)
      step(1'b0, 1'b0, 9'd0, 1'b1);
    chk("drain_empty", 32'(exp_out_q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Monitor: issues and output beats are compared against the scoreboard queues.
  logic       stall_prev = 1'b0;
  logic [8:0] data_prev = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (vin) begin
        if (exp_iss_q.size() == 0) miss("unexpected_issue");
        else chk("issue_triplet", 32'({din0, din1, din2}), 32'(exp_iss_q.pop_front()));
      end
      if (stall_prev) chk("out_hold", 32'({out_valid, out_data}), 32'({1'b1, data_prev}));
      if (out_valid && out_ready) begin
        if (exp_out_q.size() == 0) miss("unexpected_out");
        else chk("out_data", 32'(out_data), 32'(exp_out_q.pop_front()));
      end
    end
    stall_prev = !rst && out_valid && !out_ready;
    data_prev  = out_data;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, a0;
    step(1'b1, 1'b0, 9'd0, 1'b0);
    step(1'b1, 1'b0, 9'd0, 1'b0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_vin", 32'(vin), 32'd0);
    chk("rst_din", 32'({din0, din1, din2}), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Directed gather of 1,2,3
    step(1'b0, 1'b1, 9'd1, 1'b1);
    step(1'b0, 1'b1, 9'd2, 1'b1);
    step(1'b0, 1'b1, 9'd3, 1'b1);
    chk("vin_before_issue", 32'(vin), 32'd0);
    step(1'b0, 1'b0, 9'd0, 1'b1);
    chk("vin_pulse", 32'(vin), 32'd1);
    chk("din_123", 32'({din0, din1, din2}), 32'({9'd1, 9'd2, 9'd3}));
    step(1'b0, 1'b0, 9'd0, 1'b1);
    chk("vin_single", 32'(vin), 32'd0);
    drain();

    // Random traffic with random backpressure
    repeat (900) step(1'b0, $urandom_range(3) != 0, 9'($urandom), $urandom_range(9) > 2);
    drain();

    // Full: no output drain, continuous input
    step(1'b1, 1'b0, 9'd0, 1'b0);
    n0 = n_vin; a0 = n_acc;
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 9'(i + 100), 1'b0);
    chk("full_issued", 32'(n_vin - n0), 32'd4);
    chk("full_accepted", 32'(n_acc - a0), 32'd14);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 9'd200, 1'b1);
      chk("release_in_ready_low", 32'(in_ready), 32'd0);
    end
    step(1'b0, 1'b0, 9'd0, 1'b0);
    chk("release_in_ready_high", 32'(in_ready), 32'd1);
    repeat (400) step(1'b0, $urandom_range(4) != 0, 9'($urandom), $urandom_range(3) != 0);
    drain();
    chk("err_clear", 32'(err), 32'd0);

    // Return with nothing in flight
    force_vout = 1'b1;
    step(1'b0, 1'b0, 9'd0, 1'b1);
    force_vout = 1'b0;
    step(1'b0, 1'b0, 9'd0, 1'b1);
    chk("err_set", 32'(err), 32'd1);
    chk("err_no_out", 32'(out_valid), 32'd0);
    repeat (3) step(1'b0, 1'b0, 9'd0, 1'b1);
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_no_out_later", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 9'd0, 1'b1);
    step(1'b0, 1'b0, 9'd0, 1'b1);
    chk("err_rst", 32'(err), 32'd0);

    // Reset mid-stream: 2 triplets in flight, 2 samples gathered
    lat_lo = 30; lat_hi = 30;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 9'(i + 50), 1'b1);
    step(1'b1, 1'b0, 9'd0, 1'b0);
    step(1'b0, 1'b0, 9'd0, 1'b0);
    lat_lo = 1; lat_hi = 3;
    chk("mid_rst_vin", 32'(vin), 32'd0);
    chk("mid_rst_din", 32'({din0, din1, din2}), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    step(1'b0, 1'b1, 9'd7, 1'b1);
    step(1'b0, 1'b1, 9'd8, 1'b1);
    step(1'b0, 1'b1, 9'd9, 1'b1);
    step(1'b0, 1'b0, 9'd0, 1'b1);
    chk("mid_rst_vin_789", 32'(vin), 32'd1);
    chk("mid_rst_din_789", 32'({din0, din1, din2}), 32'({9'd7, 9'd8, 9'd9}));
    drain();
    chk("mid_rst_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
